// File: rtl/distance_pkg.sv
`default_nettype none
// ============================================================================
// Module   : distance_pkg
// Purpose  : Shared definitions for the vector distance core: FSM state
//            encoding, distance-metric mode constants and the accumulator
//            width helper.
// Revision : 1.0 - initial release
// ============================================================================
package distance_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DRAIN    = 2'd2,
    WAIT_ACK = 2'd3
  } state_t;

  localparam logic MODE_L2 = 1'b0;
  localparam logic MODE_L1 = 1'b1;

  // Each term is at most 2W bits wide; summing DIMS of them needs
  // clog2(DIMS) extra bits of headroom (none for a single element).
  function automatic int acc_width(input int w, input int dims);
    return 2 * w + ((dims > 1) ? $clog2(dims) : 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/distance_term.sv
`default_nettype none
// ============================================================================
// Module   : distance_term
// Purpose  : Two-stage per-element term pipeline.
//            Stage 1 registers d = |a - b|, stage 2 registers d*d (L2) or
//            d zero-extended (L1). Each stage carries its own valid bit.
// Ports    : clock, reset_n    - clock, async active-low reset
//            in_valid          - a/b hold an accepted element pair
//            mode              - latched metric (MODE_L2 / MODE_L1)
//            a, b              - element pair, W bits unsigned
//            d_valid           - stage 1 holds a valid difference
//            term_valid, term  - stage 2 output, 2W bits
// Revision : 1.0 - initial release
// ============================================================================
module distance_term
  import distance_pkg::*;
#(
  parameter int W = 32
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           in_valid,
  input  logic           mode,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           d_valid,
  output logic           term_valid,
  output logic [2*W-1:0] term
);

  logic [W-1:0]   r_d;
  logic           r_d_valid;
  logic [2*W-1:0] r_term;
  logic           r_term_valid;

  // Compare first so the subtraction never wraps.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_d       <= '0;
      r_d_valid <= 1'b0;
    end else begin
      r_d_valid <= in_valid;
      if (in_valid) begin
        r_d <= (a >= b) ? (a - b) : (b - a);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_term       <= '0;
      r_term_valid <= 1'b0;
    end else begin
      r_term_valid <= r_d_valid;
      if (r_d_valid) begin
        if (mode == MODE_L1) begin
          r_term <= (2*W)'(r_d);
        end else begin
          r_term <= (2*W)'(r_d) * (2*W)'(r_d);
        end
      end
    end
  end

  assign d_valid    = r_d_valid;
  assign term_valid = r_term_valid;
  assign term       = r_term;

endmodule
`default_nettype wire

// File: rtl/vector_distance_core.sv
`default_nettype none
// ============================================================================
// Module   : vector_distance_core
// Purpose  : Streams DIMS element pairs, computes squared-L2 or L1 distance
//            through a 3-stage pipeline (diff, term, accumulate) and holds
//            the result with a stb/ack handshake.
// Ports    : clock, reset_n    - clock, async active-low reset
//            start, mode       - begin a vector (IDLE only), metric select
//            a, b, elem_valid  - element pair stream
//            elem_ready        - high only while collecting elements
//            stb, ack, z       - result valid / consumed / result value
// Revision : 1.0 - initial release
// ============================================================================
module vector_distance_core
  import distance_pkg::*;
#(
  parameter  int W     = 32,
  parameter  int DIMS  = 4,
  localparam int ACC_W = acc_width(W, DIMS)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             mode,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             elem_valid,
  output logic             elem_ready,
  output logic             stb,
  input  logic             ack,
  output logic [ACC_W-1:0] z
);

  localparam int CNT_W = $clog2(DIMS + 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mode;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_z;

  logic             w_accept;
  logic             w_last;
  logic             w_final;
  logic             w_start;
  logic             w_d_valid;
  logic             w_term_valid;
  logic [2*W-1:0]   w_term;
  logic [ACC_W-1:0] w_sum;

  distance_term #(.W(W)) u_term (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (w_accept),
    .mode       (r_mode),
    .a          (a),
    .b          (b),
    .d_valid    (w_d_valid),
    .term_valid (w_term_valid),
    .term       (w_term)
  );

  assign w_accept = elem_valid & elem_ready;
  assign w_last   = w_accept && (r_cnt == CNT_W'(DIMS - 1));
  assign w_start  = (r_state == IDLE) && start;
  assign w_sum    = r_acc + ACC_W'(w_term);
  // No element can enter while draining, so the term being added with
  // stage 1 empty is the final one.
  assign w_final  = (r_state == DRAIN) && w_term_valid && !w_d_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    elem_ready   = 1'b0;
    stb          = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = COLLECT;
      end
      COLLECT: begin
        elem_ready = 1'b1;
        if (w_last) w_state_next = DRAIN;
      end
      DRAIN: begin
        if (w_final) w_state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        stb = 1'b1;
        if (ack) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // z is only cleared by a new start so the last result survives the ack.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mode <= MODE_L2;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_z    <= '0;
    end else if (w_start) begin
      r_mode <= mode;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_z    <= '0;
    end else begin
      if (w_accept)     r_cnt <= r_cnt + CNT_W'(1);
      if (w_term_valid) r_acc <= w_sum;
      if (w_final)      r_z   <= w_sum;
    end
  end

  assign z = r_z;

endmodule
`default_nettype wire

// File: doc/vector_distance_core.md
VECTOR_DISTANCE_CORE -- requirements
Module: vector_distance_core

Interface
REQ-001 SHALL have parameter W, default 32, width of each unsigned vector element.
REQ-002 SHALL have parameter DIMS, default 4, elements per vector, range 1..1024.
REQ-003 SHALL have derived constant ACC_W = 2*W + clog2(DIMS), with clog2(1)=0, giving accumulator width; at defaults ACC_W = 66.
REQ-004 SHALL have port clock, input, 1: single clock, all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: request to begin a new vector distance; sampled only in IDLE.
REQ-007 SHALL have port mode, input, 1: distance metric, 0 = squared L2, 1 = L1; sampled with start.
REQ-008 SHALL have port a, input, W: element of vector A.
REQ-009 SHALL have port b, input, W: element of vector B.
REQ-010 SHALL have port elem_valid, input, 1: a/b hold a valid element pair.
REQ-011 SHALL have port elem_ready, output, 1: block accepts an element pair this cycle.
REQ-012 SHALL have port stb, output, 1: result valid on z.
REQ-013 SHALL have port ack, input, 1: consumer has taken z.
REQ-014 SHALL have port z, output, ACC_W: distance result.

Function
REQ-015 SHALL implement FSM states IDLE, COLLECT, DRAIN, WAIT_ACK.
REQ-016 In IDLE, start=1 SHALL: latch mode; clear accumulator and element counter; go to COLLECT.
REQ-017 elem_ready SHALL be 1 only in COLLECT.
REQ-018 An element SHALL be accepted on a rising edge where elem_valid=1 and elem_ready=1; elem_valid=0 cycles SHALL be bubbles with no effect.
REQ-019 Stage 1 SHALL register d = |a - b| as an unsigned W-bit value, with no wrap.
REQ-020 Stage 2 SHALL register term = d*d (2W bits) in L2 mode, or d zero-extended to 2W bits in L1 mode.
REQ-021 Stage 3 SHALL add term, zero-extended, into the ACC_W-bit accumulator; overflow is impossible by construction.
REQ-022 When the DIMS-th element is accepted, the FSM SHALL go to DRAIN on that edge, and elem_ready SHALL drop on the same edge.
REQ-023 DRAIN SHALL last until the final term has been accumulated, exactly 2 edges after the last acceptance; on that edge stb SHALL become 1, z SHALL hold the final sum, and the FSM SHALL enter WAIT_ACK.
REQ-024 Latency SHALL be as follows: with the last element accepted at edge k, stb=1 after edge k+2; for back-to-back elements, total = DIMS+2 cycles from the first acceptance.
REQ-025 In WAIT_ACK, z and stb SHALL stay stable until ack=1; on that edge stb SHALL go to 0 and the FSM SHALL go to IDLE.
REQ-026 ack SHALL be ignored outside WAIT_ACK; start SHALL be ignored outside IDLE.
REQ-027 A new start SHALL be accepted in the cycle after the ack edge; no overlap of vectors.
REQ-028 A mode change mid-vector SHALL have no effect; the latched mode applies.
REQ-029 z SHALL retain the last result after ack, until the next start clears it.

Reset
REQ-030 reset_n=0 SHALL immediately, asynchronously, force: state = IDLE, stb = 0, elem_ready = 0, z = 0, accumulator = 0, counter = 0, pipeline valid bits = 0, latched mode = 0.
REQ-031 Reset mid-COLLECT/DRAIN/WAIT_ACK SHALL abort the vector with no stb pulse; after release, the block SHALL accept start on the first edge.

Structure
REQ-032 Package distance_pkg SHALL hold the FSM state encoding, mode constants (MODE_L2=0, MODE_L1=1), and the ACC_W width function.
REQ-033 Sub-module distance_term(W) SHALL contain stages 1–2: abs-diff, then square or pass-through, with a valid bit per stage; the top SHALL hold the FSM, counter and accumulator.

Verification
REQ-034 Defaults, L2, A=(1,2,3,4), B=(4,2,1,0), back-to-back -> z=29, stb exactly 2 edges after 4th acceptance.
REQ-035 Defaults, L1, same vectors with elem_valid gaps of 0/3/1 cycles -> z=9; gaps extend latency only.
REQ-036 W=32, DIMS=4, L2, all a=0xFFFFFFFF, b=0 -> z=4*(2^32-1)^2, no overflow.
REQ-037 stb held 5 cycles before ack, start pulsed during WAIT_ACK -> z stable, start ignored, next start 1 cycle after ack accepted.
REQ-038 reset_n low after 2 accepted elements, then a new vector A=(5,5,5,5), B=(2,2,2,2) L2 -> no stb before reset, z=36 after.
REQ-039 DIMS=1, L2, a=7, b=10 -> z=9, stb 2 edges after the single acceptance.
